// File: rtl/npu_act_skew_feeder.sv
// Activation skew feeder: issues broadcast row-bank reads for K cycles and
// diagonally skews the returned per-row words onto the systolic array west edge.
module npu_act_skew_feeder #(
    parameter int ARRAY_N    = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DWidth     = 8,
    parameter int K_WIDTH    = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          flush_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [$clog2(ARRAY_N):0]      num_rows_i,
    input  logic [K_WIDTH-1:0]            k_i,
    output logic                          rd_en_o,
    output logic [ADDR_WIDTH-1:0]         rd_addr_o,
    input  logic [ARRAY_N*DWidth-1:0]     rd_data_i,
    output logic [ARRAY_N*DWidth-1:0]     act_data_o,
    output logic [ARRAY_N-1:0]            act_valid_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int NW = $clog2(ARRAY_N) + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state_q;
    logic                  start_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [K_WIDTH-1:0]    k_q;
    logic [K_WIDTH-1:0]    cnt_q;
    logic [NW-1:0]         m_q;
    logic [NW-1:0]         drain_q;
    logic [NW-1:0]         rows_d;
    logic                  start_edge_d;

    logic                  en_d_q;
    logic [ARRAY_N-1:0]    cap_vld_q;
    logic [DWidth-1:0]     cap_data_q [ARRAY_N];
    logic [DWidth-1:0]     dly_data_q [ARRAY_N][ARRAY_N];
    logic [ARRAY_N-1:0]    dly_vld_q  [ARRAY_N];

    assign rows_d       = (num_rows_i > NW'(ARRAY_N)) ? NW'(ARRAY_N) : num_rows_i;
    assign start_edge_d = start_i & ~start_q;

    assign rd_en_o   = (state_q == S_READ);
    assign rd_addr_o = rd_en_o ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            base_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            drain_q <= '0;
        end else begin
            start_q <= start_i;
            if (flush_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                cnt_q   <= '0;
                drain_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        done_q <= 1'b0;
                        if (start_edge_d) begin
                            base_q  <= base_addr_i;
                            k_q     <= k_i;
                            m_q     <= rows_d;
                            cnt_q   <= '0;
                            drain_q <= '0;
                            busy_q  <= 1'b1;
                            if (k_i == '0 || rows_d == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_READ;
                            end
                        end
                    end
                    S_READ: begin
                        if (cnt_q == k_q - K_WIDTH'(1)) begin
                            state_q <= S_DRAIN;
                            drain_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + K_WIDTH'(1);
                        end
                    end
                    S_DRAIN: begin
                        // M+1 drain cycles: capture stage plus M-1 skew stages plus last output
                        if (drain_q == m_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + NW'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_d_q    <= 1'b0;
            cap_vld_q <= '0;
            for (int unsigned r = 0; r < ARRAY_N; r++) begin
                cap_data_q[r] <= '0;
                dly_vld_q[r]  <= '0;
                for (int unsigned j = 0; j < ARRAY_N; j++) begin
                    dly_data_q[r][j] <= '0;
                end
            end
        end else if (flush_i) begin
            en_d_q    <= 1'b0;
            cap_vld_q <= '0;
            for (int unsigned r = 0; r < ARRAY_N; r++) begin
                cap_data_q[r] <= '0;
                dly_vld_q[r]  <= '0;
                for (int unsigned j = 0; j < ARRAY_N; j++) begin
                    dly_data_q[r][j] <= '0;
                end
            end
        end else begin
            en_d_q <= rd_en_o;
            for (int unsigned r = 0; r < ARRAY_N; r++) begin
                // Rows beyond M are masked at capture so zeros flow down their skew chain
                if (en_d_q && (NW'(r) < m_q)) begin
                    cap_vld_q[r]  <= 1'b1;
                    cap_data_q[r] <= rd_data_i[r*DWidth +: DWidth];
                end else begin
                    cap_vld_q[r]  <= 1'b0;
                    cap_data_q[r] <= '0;
                end
                dly_vld_q[r][0]  <= cap_vld_q[r];
                dly_data_q[r][0] <= cap_data_q[r];
                for (int unsigned j = 1; j < ARRAY_N; j++) begin
                    dly_vld_q[r][j]  <= dly_vld_q[r][j-1];
                    dly_data_q[r][j] <= dly_data_q[r][j-1];
                end
            end
        end
    end

    always_comb begin
        act_data_o  = '0;
        act_valid_o = '0;
        for (int unsigned r = 0; r < ARRAY_N; r++) begin
            if (r == 0) begin
                act_data_o[r*DWidth +: DWidth] = cap_data_q[r];
                act_valid_o[r]                 = cap_vld_q[r];
            end else begin
                act_data_o[r*DWidth +: DWidth] = dly_data_q[r][r-1];
                act_valid_o[r]                 = dly_vld_q[r][r-1];
            end
        end
    end

endmodule

// File: tb/tb_npu_act_skew_feeder.sv
// Directed bench for npu_act_skew_feeder: per-cycle scoreboard of reads,
// skewed activations, busy and done, filled when each job is launched.
module tb_npu_act_skew_feeder;
    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int KW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              flush_i;
    logic [AW-1:0]     base_addr_i;
    logic [4:0]        num_rows_i;
    logic [KW-1:0]     k_i;
    logic              rd_en_o;
    logic [AW-1:0]     rd_addr_o;
    logic [N*DW-1:0]   rd_data_i;
    logic [N*DW-1:0]   act_data_o;
    logic [N-1:0]      act_valid_o;
    logic              busy_o;
    logic              done_o;

    npu_act_skew_feeder #(.ARRAY_N(N), .ADDR_WIDTH(AW), .DWidth(DW), .K_WIDTH(KW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .flush_i(flush_i),
        .base_addr_i(base_addr_i), .num_rows_i(num_rows_i), .k_i(k_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .act_data_o(act_data_o), .act_valid_o(act_valid_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
    typedef struct { int cyc; logic [N-1:0] vld; logic [N*DW-1:0] data; } act_t;

    rd_t  rq[$];
    act_t aq[$];
    int   dq[$];
    int   cyc = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   last_done = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: word for row r at address a is {r[3:0], a[3:0]}; junk when not read.
    logic          prev_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        for (int r = 0; r < N; r++) begin
            if (prev_en) rd_data_i[r*DW +: DW] = {4'(r), prev_addr[3:0]};
            else         rd_data_i[r*DW +: DW] = 8'($urandom);
        end
        prev_en   = rd_en_o;
        prev_addr = rd_addr_o;
    end

    rd_t          m_rd;
    act_t         m_act;
    int           m_d;
    logic         e_en, e_done, e_busy;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_vld;
    logic [N*DW-1:0] e_data;

    always @(negedge clk) begin
        e_en = 1'b0; e_addr = '0; e_vld = '0; e_data = '0; e_done = 1'b0;
        if (rq.size() != 0 && rq[0].cyc == cyc) begin
            m_rd = rq.pop_front(); e_en = 1'b1; e_addr = m_rd.addr;
        end
        if (aq.size() != 0 && aq[0].cyc == cyc) begin
            m_act = aq.pop_front(); e_vld = m_act.vld; e_data = m_act.data;
        end
        if (dq.size() != 0 && dq[0] == cyc) begin
            m_d = dq.pop_front(); e_done = 1'b1;
        end
        e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        checks++;
        assert (rd_en_o === e_en) else begin failures++; $error("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en_o, e_en); end
        checks++;
        assert (rd_addr_o === e_addr) else begin failures++; $error("FAIL rd_addr cyc=%0d got=%h exp=%h", cyc, rd_addr_o, e_addr); end
        checks++;
        assert (act_valid_o === e_vld) else begin failures++; $error("FAIL act_valid cyc=%0d got=%h exp=%h", cyc, act_valid_o, e_vld); end
        checks++;
        assert (act_data_o === e_data) else begin failures++; $error("FAIL act_data cyc=%0d got=%h exp=%h", cyc, act_data_o, e_data); end
        checks++;
        assert (done_o === e_done) else begin failures++; $error("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, e_done); end
        checks++;
        assert (busy_o === e_busy) else begin failures++; $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, e_busy); end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_job(input logic [AW-1:0] base, input int k, input int mraw, input int c0);
        int m;
        act_t e;
        logic [AW-1:0] a;
        m = (mraw > N) ? N : mraw;
        if (k == 0 || m == 0) begin
            dq.push_back(c0);
            busy_lo = c0; busy_hi = c0; last_done = c0;
        end else begin
            for (int t = 0; t < k; t++) rq.push_back('{cyc: c0 + t, addr: base + AW'(t)});
            for (int c = c0 + 2; c <= c0 + k + m; c++) begin
                e.cyc = c; e.vld = '0; e.data = '0;
                for (int r = 0; r < m; r++) begin
                    if (c - c0 - 2 - r >= 0 && c - c0 - 2 - r < k) begin
                        a = base + AW'(c - c0 - 2 - r);
                        e.vld[r] = 1'b1;
                        e.data[r*DW +: DW] = {4'(r), a[3:0]};
                    end
                end
                aq.push_back(e);
            end
            last_done = c0 + k + m + 1;
            dq.push_back(last_done);
            busy_lo = c0; busy_hi = last_done;
        end
    endtask

    task automatic launch(input logic [AW-1:0] base, input int k, input int m);
        start_i = 1'b0;
        tick();
        base_addr_i = base; k_i = KW'(k); num_rows_i = 5'(m); start_i = 1'b1;
        push_job(base, k, m, cyc + 1);
    endtask

    task automatic wait_job();
        repeat (last_done + 3 - cyc) tick();
    endtask

    task automatic truncate(input int f);
        rd_t x; act_t y; int z;
        while (rq.size() != 0 && rq[rq.size()-1].cyc > f) x = rq.pop_back();
        while (aq.size() != 0 && aq[aq.size()-1].cyc > f) y = aq.pop_back();
        while (dq.size() != 0 && dq[dq.size()-1] > f) z = dq.pop_back();
        if (busy_hi > f) busy_hi = f;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        assert (rd_en_o === 1'b0 && rd_addr_o === '0 && busy_o === 1'b0 && done_o === 1'b0)
        else begin failures++; $error("FAIL %s ctl got=%b/%h/%b/%b exp=0/0/0/0", tag, rd_en_o, rd_addr_o, busy_o, done_o); end
        checks++;
        assert (act_valid_o === '0 && act_data_o === '0)
        else begin failures++; $error("FAIL %s act got=%h/%h exp=0/0", tag, act_valid_o, act_data_o); end
    endtask

    initial begin
        int c0;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        base_addr_i = '0; num_rows_i = '0; k_i = '0; rd_data_i = '0;
        repeat (2) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Basic job; inputs scrambled after the start edge must not matter.
        launch(32'h10, 3, 4);
        tick();
        base_addr_i = 32'hABCD; k_i = 9; num_rows_i = 5'd1;
        wait_job();

        // Full array with address wrap, M given as 16 then 20 (clamped).
        launch(32'hFFFF_FFF8, 16, 16);
        wait_job();
        launch(32'hFFFF_FFF8, 16, 20);
        wait_job();

        // Degenerate jobs.
        launch(32'h100, 0, 5);
        wait_job();
        launch(32'h200, 4, 0);
        wait_job();

        // Second start edge during DRAIN is ignored; held start does not relaunch.
        launch(32'h300, 2, 2);
        c0 = cyc + 1;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        start_i = 1'b1;
        wait_job();
        repeat (8) tick();

        // Flush during READ at c0+3.
        launch(32'h400, 8, 8);
        c0 = cyc + 1;
        repeat (4) tick();
        flush_i = 1'b1;
        truncate(c0 + 3);
        tick();
        flush_i = 1'b0;
        check_idle("flush");
        repeat (3) tick();

        // Start edge coincident with flush is discarded.
        start_i = 1'b0;
        tick();
        start_i = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (5) tick();
        launch(32'h500, 3, 3);
        wait_job();

        // Asynchronous reset mid-READ.
        launch(32'h600, 6, 3);
        repeat (2) tick();
        #1;
        rst = 1'b1; start_i = 1'b0;
        truncate(cyc - 1);
        #1;
        check_idle("async_rst");
        tick();
        rst = 1'b0;
        tick();
        launch(32'h700, 3, 5);
        wait_job();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
